// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: controller opcodes, default bus widths
// (overridable through `MEM_ADDR_WIDTH / `MEM_DATA_WIDTH) and the tag-width helper.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 28
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 512
`endif

package mem_port_arbiter_pkg;
  localparam logic [2:0] MEMC_INSTR_WR = 3'b000;
  localparam logic [2:0] MEMC_INSTR_RD = 3'b001;
  localparam int DEF_ADDR_W = `MEM_ADDR_WIDTH;
  localparam int DEF_DATA_W = `MEM_DATA_WIDTH;

  // Never returns 0 so a single-port ring still gets a 1-bit index.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/mem_port_rr_arb.sv
// Round-robin one-hot arbiter; the search starts one past the last granted port.
module mem_port_rr_arb
  import mem_port_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         en_i,
  output logic [N-1:0] grant_o
);
  localparam int PW = clog2(N);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant_o = '0;
    ptr_d   = ptr_q;
    idx     = '0;
    found   = 1'b0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        idx = PW'((int'(ptr_q) + k) % N);
        if (!found && req_i[idx]) begin
          found        = 1'b1;
          grant_o[idx] = 1'b1;
          ptr_d        = PW'((int'(idx) + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates NUM_WR writers and NUM_RD readers onto one memory-controller port; read data
// is routed back in order through a tag FIFO. Optional counters: MEM_PORT_ARBITER_PERF_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_WR   = 3,
  parameter int NUM_RD   = 2,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_DEPTH = 16,
  parameter int WR_PRIO  = 1
) (
  input  logic                     eclk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wvalid,
  output logic [NUM_WR-1:0]        wready,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        rvalid_req,
  output logic [NUM_RD-1:0]        rready_req,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0]        rdata,
  output logic [NUM_RD-1:0]        rvalid,
  input  logic                     memc_cmd_full,
  output logic                     memc_cmd_en,
  output logic [2:0]               memc_cmd_instr,
  output logic [5:0]               memc_cmd_bl,
  output logic [ADDR_W-1:0]        memc_cmd_addr,
  input  logic                     memc_wr_full,
  output logic                     memc_wr_en,
  output logic                     memc_wr_end,
  output logic [DATA_W/8-1:0]      memc_wr_mask,
  output logic [DATA_W-1:0]        memc_wr_data,
  input  logic                     memc_rd_empty,
  input  logic [DATA_W-1:0]        memc_rd_data,
  output logic                     memc_rd_en,
  output logic                     proto_err
`ifdef MEM_PORT_ARBITER_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_rd_outstanding_max
`endif
);
  localparam int TAG_W = clog2(NUM_RD);
  localparam int PTR_W = clog2(RD_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              wr_elig, rd_elig, tag_full;
  logic [NUM_WR-1:0] wgrant;
  logic [NUM_RD-1:0] rgrant;
  logic [ADDR_W-1:0] sel_waddr, sel_raddr;
  logic [DATA_W-1:0] sel_wdata;
  logic [TAG_W-1:0]  sel_rtag;

  assign wr_elig = !memc_cmd_full && !memc_wr_full;
  assign rd_elig = !memc_cmd_full && !tag_full;

  generate
    if (WR_PRIO != 0) begin : g_prio
      // A granted write suppresses the read ring entirely, so its pointer does not move.
      mem_port_rr_arb #(.N(NUM_WR)) u_wr_arb (
        .clk_i(eclk), .rst_i(rst), .req_i(wvalid), .en_i(wr_elig), .grant_o(wgrant)
      );
      mem_port_rr_arb #(.N(NUM_RD)) u_rd_arb (
        .clk_i(eclk), .rst_i(rst), .req_i(rvalid_req), .en_i(rd_elig && !(|wgrant)),
        .grant_o(rgrant)
      );
    end else begin : g_ring
      logic [NUM_WR+NUM_RD-1:0] req, gnt;
      assign req = {rvalid_req & {NUM_RD{rd_elig}}, wvalid & {NUM_WR{wr_elig}}};
      mem_port_rr_arb #(.N(NUM_WR + NUM_RD)) u_arb (
        .clk_i(eclk), .rst_i(rst), .req_i(req), .en_i(1'b1), .grant_o(gnt)
      );
      assign wgrant = gnt[NUM_WR-1:0];
      assign rgrant = gnt[NUM_WR+NUM_RD-1:NUM_WR];
    end
  endgenerate

  assign wready     = wgrant;
  assign rready_req = rgrant;

  always_comb begin
    sel_waddr = '0;
    sel_wdata = '0;
    sel_raddr = '0;
    sel_rtag  = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (wgrant[i]) begin
        sel_waddr = waddr[i*ADDR_W +: ADDR_W];
        sel_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
    for (int j = 0; j < NUM_RD; j++) begin
      if (rgrant[j]) begin
        sel_raddr = raddr[j*ADDR_W +: ADDR_W];
        sel_rtag  = TAG_W'(j);
      end
    end
  end

  // Issue stage: one registered command per accepted request
  logic              cmd_en_q, cmd_en_d, wr_en_q, wr_en_d;
  logic [2:0]        instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  always_comb begin
    cmd_en_d  = (|wgrant) || (|rgrant);
    wr_en_d   = |wgrant;
    instr_d   = instr_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    if (|wgrant) begin
      instr_d   = MEMC_INSTR_WR;
      addr_d    = sel_waddr;
      wr_data_d = sel_wdata;
    end else if (|rgrant) begin
      instr_d = MEMC_INSTR_RD;
      addr_d  = sel_raddr;
    end
  end

  // Tag FIFO and return stage
  logic [TAG_W-1:0]  tag_mem [RD_DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push, pop, err;
  logic [NUM_RD-1:0] rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              proto_err_q, proto_err_d;

  assign tag_full = (cnt_q == CNT_W'(RD_DEPTH));
  assign push     = |rgrant;
  assign pop      = !memc_rd_empty && (cnt_q != '0);
  assign err      = !memc_rd_empty && (cnt_q == '0);

  always_comb begin
    wp_d        = wp_q + PTR_W'(push);
    rp_d        = rp_q + PTR_W'(pop);
    cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rvalid_d    = pop ? (NUM_RD'(1) << tag_mem[rp_q]) : '0;
    rdata_d     = pop ? memc_rd_data : rdata_q;
    proto_err_d = proto_err_q || err;
  end

  always_ff @(posedge eclk) begin
    if (push) tag_mem[wp_q] <= sel_rtag;
  end

  always_ff @(posedge eclk or posedge rst) begin
    if (rst) begin
      cmd_en_q    <= 1'b0;
      wr_en_q     <= 1'b0;
      instr_q     <= '0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      wp_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      cmd_en_q    <= cmd_en_d;
      wr_en_q     <= wr_en_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign memc_cmd_en    = cmd_en_q;
  assign memc_cmd_instr = instr_q;
  assign memc_cmd_bl    = 6'd0;
  assign memc_cmd_addr  = addr_q;
  assign memc_wr_en     = wr_en_q;
  assign memc_wr_end    = wr_en_q;
  assign memc_wr_mask   = '0;
  assign memc_wr_data   = wr_data_q;
  assign memc_rd_en     = !memc_rd_empty;
  assign rvalid         = rvalid_q;
  assign rdata          = rdata_q;
  assign proto_err      = proto_err_q;

`ifdef MEM_PORT_ARBITER_PERF_EN
  logic [31:0] stall_q, stall_d, hwm_q, hwm_d;

  always_comb begin
    stall_d = stall_q;
    hwm_d   = hwm_q;
    if (((|wvalid) || (|rvalid_req)) && !cmd_en_d && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (32'(cnt_q) > hwm_q) hwm_d = 32'(cnt_q);
  end

  always_ff @(posedge eclk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      hwm_q   <= '0;
    end else begin
      stall_q <= stall_d;
      hwm_q   <= hwm_d;
    end
  end

  assign perf_stall_cnt          = stall_q;
  assign perf_rd_outstanding_max = hwm_q;
`endif
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised successor to the fixed three-writer/two-reader memory gasket. It arbitrates NUM_WR write requesters and NUM_RD read requesters onto one memory-controller command/write/read interface.
- Read data returns in order and is routed to the issuing requester through a tag FIFO.
- Sits between the compute cores (blake2b, radix, collision, and future ones) and the DDR controller.

Parameters:
- NUM_WR, 3: number of write requesters (1..8).
- NUM_RD, 2: number of read requesters (1..8).
- ADDR_W, 28: memory address width.
- DATA_W, 512: data width; memc_wr_mask is DATA_W/8 bits wide.
- RD_DEPTH, 16: maximum outstanding reads; depth of the tag FIFO (power of 2).
- WR_PRIO, 1: 1 = any pending write beats any read; 0 = one round-robin ring over all NUM_WR+NUM_RD requesters (writes occupy slots 0..NUM_WR-1).

Ports:
- eclk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- wvalid  in  NUM_WR  per-port write request
- wready  out  NUM_WR  one-hot grant; a write is accepted on wvalid&wready
- waddr  in  NUM_WR*ADDR_W  flattened, port i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_WR*DATA_W  flattened write data
- rvalid_req  in  NUM_RD  per-port read request
- rready_req  out  NUM_RD  one-hot grant
- raddr  in  NUM_RD*ADDR_W  flattened read address
- rdata  out  DATA_W  return data, broadcast to all read ports
- rvalid  out  NUM_RD  one-hot return strobe
- memc_cmd_full  in  1  controller command FIFO full
- memc_cmd_en  out  1  command push
- memc_cmd_instr  out  3  3'b000 write, 3'b001 read
- memc_cmd_bl  out  6  always 0 (single beat)
- memc_cmd_addr  out  ADDR_W  command address
- memc_wr_full  in  1  controller write-data FIFO full
- memc_wr_en  out  1  write-data push
- memc_wr_end  out  1  equals memc_wr_en
- memc_wr_mask  out  DATA_W/8  always 0 (all bytes written)
- memc_wr_data  out  DATA_W  write data
- memc_rd_empty  in  1  controller read FIFO empty
- memc_rd_data  in  DATA_W  controller read data
- memc_rd_en  out  1  read pop; combinational, equal to !memc_rd_empty
- proto_err  out  1  sticky error flag: read data arrived with the tag FIFO empty

Behaviour:
- Reset:
  - All registered outputs are 0, and proto_err is 0.
  - Round-robin pointers return to 0 and the tag FIFO is emptied.
  - Reset mid-operation drops in-flight tags. The reset owner must also reset the controller.
- Grant (combinational, from the current-cycle requests):
  - Write eligible when !memc_cmd_full && !memc_wr_full.
  - Read eligible when !memc_cmd_full && tag FIFO not full.
  - At most one grant per cycle across all ports.
  - Round-robin: the search starts at the port after the last granted one; with a single requester, that requester is granted every eligible cycle.
- Issue (registered, 1-cycle latency):
  - The cycle after an accepted write: memc_cmd_en=1, instr=000, memc_cmd_addr=waddr[i], memc_wr_en=memc_wr_end=1, memc_wr_data=wdata[i].
  - The cycle after an accepted read: memc_cmd_en=1, instr=001, memc_cmd_addr=raddr[j], memc_wr_en=0. In the same acceptance cycle, j is pushed into the tag FIFO.
  - Issue strobes are low in every other cycle.
- Return:
  - Each cycle memc_rd_empty=0: pop the tag FIFO head t.
  - Next cycle: rdata=memc_rd_data, rvalid=1<<t.
  - rdata holds its last value while rvalid=0.
- Tag FIFO:
  - Push and pop in the same cycle are allowed when the FIFO is neither empty nor full; occupancy is unchanged.
  - Push when full is never attempted, because the grant is blocked.
  - Pop when empty sets proto_err, and rvalid stays 0.
  - Pointers wrap modulo RD_DEPTH.
- Full mid-stream: when memc_cmd_full rises, no grant is issued that cycle. Requests stay pending and requesters must hold valid and address stable.

Optional Feature:
- Macro MEM_PORT_ARBITER_PERF_EN.
- Defined: adds 32-bit outputs perf_stall_cnt (cycles with any request pending but no grant) and perf_rd_outstanding_max (high-water mark of tag FIFO occupancy). Both are reset to 0 and perf_stall_cnt saturates at all-ones.
- Undefined: these ports and their logic are absent.

Decomposition:
- Shared package/defines: MEMC_INSTR_WR=3'b000, MEMC_INSTR_RD=3'b001, default ADDR_W/DATA_W (`MEM_ADDR_WIDTH/`MEM_DATA_WIDTH), and the tag width function clog2(NUM_RD).
- One sub-module: mem_port_rr_arb (parametrised round-robin one-hot arbiter with pointer update on grant), instantiated once per ring: two rings with WR_PRIO=1, one combined ring with WR_PRIO=0.

Test Plan:
- Single write, NUM_WR=3: port1 request, addr 0x100, data 0xA5..., nothing full -> wready=3'b010 that cycle; next cycle memc_cmd_en=1, instr=000, addr 0x100, wr_en=1, wr_end=1, mask=0.
- Round-robin: all 3 write ports held valid for 6 cycles -> grant order 0,1,2,0,1,2 with no gaps.
- Read routing, NUM_RD=2: port0 reads 0x10, then port1 reads 0x20; controller returns D0 then D1 -> rvalid=01 with D0, then 10 with D1, each 1 cycle after rd_empty=0.
- Outstanding limit, RD_DEPTH=4: 5 back-to-back reads, no returns -> 4 accepted, 5th held (rready_req=0) until 1 return, then accepted the next cycle.
- Backpressure and error: memc_cmd_full=1 for 3 cycles with a pending write -> no grant and no cmd_en; data held. Inject rd_empty=0 with no reads outstanding -> proto_err=1, stays 1 until rst.
- Priority and reset, WR_PRIO=1: simultaneous write and read -> write granted first, read next cycle. Assert rst with 2 reads outstanding -> all outputs 0 and tag FIFO empty.
